// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, operand selects, FSM states.
package exec_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] SELA_PC4  = 2'b00;
  localparam logic [1:0] SELA_FWD  = 2'b01;
  localparam logic [1:0] SELA_DOA  = 2'b10;
  localparam logic [1:0] SELA_ZERO = 2'b11;

  localparam logic [1:0] SELB_DOB  = 2'b00;
  localparam logic [1:0] SELB_IMM  = 2'b01;
  localparam logic [1:0] SELB_ZERO = 2'b10;
  localparam logic [1:0] SELB_FWD  = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_REDUCE
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational WIDTH-bit ALU with zero/negative flags.
// Shift amounts use b[4:0]; carries are dropped.
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             n
);

  always_comb begin
    y = '0;
    unique case (ctrl)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SRL:   y = a >> b[4:0];
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign z = (y == '0);
  assign n = y[WIDTH-1];

endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage: operand muxes, ALU, serial window-max reducer
// and the EX/MEM output register with stall/flush control.
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIX_W = 8,
  parameter int NPIX  = 5,
  parameter int REG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  sel_res,
  input  logic [2:0]            alu_ctrl,
  input  logic [1:0]            sel_op_a,
  input  logic [1:0]            sel_op_b,
  input  logic [WIDTH-1:0]      pc_plus4,
  input  logic [WIDTH-1:0]      do_a,
  input  logic [WIDTH-1:0]      do_b,
  input  logic [WIDTH-1:0]      imm,
  input  logic [WIDTH-1:0]      fwd,
  input  logic [NPIX*PIX_W-1:0] window,
  input  logic [REG_W-1:0]      rg_in,
  output logic                  out_valid,
  output logic [REG_W-1:0]      rg_out,
  output logic [7:0]            dob_byte,
  output logic [WIDTH-1:0]      result,
  output logic                  n,
  output logic                  z
);

  localparam int CW = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PIX_W-1:0]        max_q, max_d, max_new;
  logic [NPIX*PIX_W-1:0]   win_q;
  logic [REG_W-1:0]        rg_q;
  logic [7:0]              byte_q;
  logic [PIX_W-1:0]        pix [NPIX];
  logic [WIDTH-1:0]        op_a, op_b, alu_y;
  logic                    alu_z, alu_n;
  logic                    accept, alu_go, win_go, final_cmp, done;

  assign in_ready  = !stall && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign alu_go    = accept && !sel_res;
  assign win_go    = accept && sel_res;
  assign final_cmp = (state_q == S_REDUCE) && (count_q == LAST);
  assign done      = final_cmp && !stall;

  always_comb begin
    op_a = '0;
    unique case (sel_op_a)
      SELA_PC4:  op_a = pc_plus4;
      SELA_FWD:  op_a = fwd;
      SELA_DOA:  op_a = do_a;
      SELA_ZERO: op_a = '0;
      default:   op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (sel_op_b)
      SELB_DOB:  op_b = do_b;
      SELB_IMM:  op_b = imm;
      SELB_ZERO: op_b = '0;
      SELB_FWD:  op_b = fwd;
      default:   op_b = '0;
    endcase
  end

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .ctrl (alu_ctrl),
    .y    (alu_y),
    .z    (alu_z),
    .n    (alu_n)
  );

  // Pixel 0 sits in the top slice of the window.
  always_comb begin
    for (int i = 0; i < NPIX; i++)
      pix[i] = win_q[(NPIX-1-i)*PIX_W +: PIX_W];
  end

  // Strict compare so ties keep the earlier pixel.
  assign max_new = (pix[count_q] > max_q) ? pix[count_q] : max_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_go) begin
          state_d = S_REDUCE;
          count_d = CW'(1);
          max_d   = window[NPIX*PIX_W-1 -: PIX_W];
        end
      end
      S_REDUCE: begin
        if (!final_cmp) begin
          max_d   = max_new;
          count_d = count_q + CW'(1);
        end else if (!stall) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      max_q   <= '0;
      win_q   <= '0;
      rg_q    <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      if (win_go) begin
        win_q  <= window;
        rg_q   <= rg_in;
        byte_q <= op_b[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rg_out    <= '0;
      dob_byte  <= '0;
      result    <= '0;
      n         <= 1'b0;
      z         <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (alu_go) begin
        out_valid <= 1'b1;
        result    <= alu_y;
        n         <= alu_n;
        z         <= alu_z;
        rg_out    <= rg_in;
        dob_byte  <= op_b[7:0];
      end else if (done) begin
        out_valid <= 1'b1;
        result    <= WIDTH'(max_new);
        n         <= 1'b0;
        z         <= (max_new == '0);
        rg_out    <= rg_q;
        dob_byte  <= byte_q;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed bench for exec_stage_pipe: ALU vector table plus
// window, stall, flush and reset sequences.
module tb_exec_stage_pipe;
  import exec_pkg::*;

  localparam int WIDTH = 32;
  localparam int PIX_W = 8;
  localparam int NPIX  = 5;
  localparam int REG_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              sel_res;
  logic [2:0]        alu_ctrl;
  logic [1:0]        sel_op_a;
  logic [1:0]        sel_op_b;
  logic [WIDTH-1:0]  pc_plus4, do_a, do_b, imm, fwd;
  logic [NPIX*PIX_W-1:0] window;
  logic [REG_W-1:0]  rg_in;
  logic              out_valid;
  logic [REG_W-1:0]  rg_out;
  logic [7:0]        dob_byte;
  logic [WIDTH-1:0]  result;
  logic              n, z;

  int tests  = 0;
  int failed = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  exec_stage_pipe #(
    .WIDTH(WIDTH), .PIX_W(PIX_W), .NPIX(NPIX), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .sel_res(sel_res), .alu_ctrl(alu_ctrl),
    .sel_op_a(sel_op_a), .sel_op_b(sel_op_b),
    .pc_plus4(pc_plus4), .do_a(do_a), .do_b(do_b),
    .imm(imm), .fwd(fwd), .window(window),
    .rg_in(rg_in), .out_valid(out_valid),
    .rg_out(rg_out), .dob_byte(dob_byte),
    .result(result), .n(n), .z(z)
  );

  typedef struct {
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  op;
    logic [31:0] pc4, a, b, im, fw;
    logic [3:0]  rg;
    logic [31:0] exp_res;
    logic        exp_z, exp_n;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic v,
                          input logic [31:0] res, input logic zz,
                          input logic nn, input logic [3:0] rg,
                          input logic [7:0] bb);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".result"}, result, res);
    chk({tag, ".z"}, 32'(z), 32'(zz));
    chk({tag, ".n"}, 32'(n), 32'(nn));
    chk({tag, ".rg_out"}, 32'(rg_out), 32'(rg));
    chk({tag, ".dob_byte"}, 32'(dob_byte), 32'(bb));
  endtask

  task automatic issue_add(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] rg);
    in_valid = 1'b1; sel_res = 1'b0; alu_ctrl = ALU_ADD;
    sel_op_a = SELA_DOA; sel_op_b = SELB_IMM;
    do_a = a; imm = b; rg_in = rg;
  endtask

  // Window op; optional stall on the final compare cycle.
  task automatic run_win(input string tag,
                         input logic [39:0] win,
                         input logic [7:0] exp_max,
                         input int stall_n);
    in_valid = 1'b1; sel_res = 1'b1; window = win;
    rg_in = 4'd9; sel_op_b = SELB_IMM; imm = 32'h0000_005A;
    chk({tag, ".rdy_accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; window = '1; rg_in = 4'd0; imm = 32'h0;
    for (int k = 1; k < NPIX - 1; k++) begin
      chk({tag, ".rdy_busy"}, 32'(in_ready), 32'd0);
      chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".held_res"}, result, last_res);
      step();
    end
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int s = 0; s < stall_n; s++) begin
        #1;
        chk({tag, ".rdy_stall"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, ".stall_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".stall_res"}, result, last_res);
      end
      stall = 1'b0;
      #1;
    end
    chk({tag, ".rdy_final"}, 32'(in_ready), 32'd0);
    step();
    chk_outs(tag, 1'b1, {24'h0, exp_max}, exp_max == 8'h0, 1'b0,
             4'd9, 8'h5A);
    chk({tag, ".rdy_done"}, 32'(in_ready), 32'd1);
    last_res = {24'h0, exp_max};
  endtask

  initial begin
    vecs[0] = '{SELA_DOA, SELB_IMM, ALU_ADD, 0, 5, 0, 7, 0, 3,
                32'd12, 0, 0, 8'h07};
    vecs[1] = '{SELA_DOA, SELB_IMM, ALU_SUB, 0, 5, 0, 5, 0, 4,
                32'd0, 1, 0, 8'h05};
    vecs[2] = '{SELA_DOA, SELB_IMM, ALU_SUB, 0, 0, 0, 1, 0, 5,
                32'hFFFF_FFFF, 0, 1, 8'h01};
    vecs[3] = '{SELA_PC4, SELB_DOB, ALU_AND, 32'h10F, 0, 32'hF0F, 0, 0,
                6, 32'h10F, 0, 0, 8'h0F};
    vecs[4] = '{SELA_FWD, SELB_ZERO, ALU_OR, 0, 0, 0, 0, 32'hF0, 7,
                32'hF0, 0, 0, 8'h00};
    vecs[5] = '{SELA_DOA, SELB_FWD, ALU_XOR, 0, 32'hFF00_FF00, 0, 0,
                32'h0F0F_0F0F, 8, 32'hF00F_F00F, 0, 1, 8'h0F};
    vecs[6] = '{SELA_DOA, SELB_IMM, ALU_SLL, 0, 1, 0, 32'h24, 0, 9,
                32'h10, 0, 0, 8'h24};
    vecs[7] = '{SELA_DOA, SELB_IMM, ALU_SRL, 0, 32'h8000_0000, 0, 31, 0,
                10, 32'h1, 0, 0, 8'h1F};
    vecs[8] = '{SELA_ZERO, SELB_DOB, ALU_PASSB, 0, 0, 32'hDEAD_BEEF, 0,
                0, 11, 32'hDEAD_BEEF, 0, 1, 8'hEF};
    vecs[9] = '{SELA_DOA, SELB_IMM, ALU_ADD, 0, 32'hFFFF_FFFF, 0, 1, 0,
                12, 32'h0, 1, 0, 8'h01};

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    sel_res = 1'b0; alu_ctrl = ALU_ADD; sel_op_a = SELA_DOA;
    sel_op_b = SELB_IMM; pc_plus4 = '0; do_a = '0; do_b = '0;
    imm = '0; fwd = '0; window = '0; rg_in = '0;
    step(); step();
    chk_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 8'h0);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back ALU issue: one result per cycle, in order.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; sel_res = 1'b0;
      sel_op_a = vecs[i].sa; sel_op_b = vecs[i].sb;
      alu_ctrl = vecs[i].op; pc_plus4 = vecs[i].pc4;
      do_a = vecs[i].a; do_b = vecs[i].b; imm = vecs[i].im;
      fwd = vecs[i].fw; rg_in = vecs[i].rg;
      #1;
      chk($sformatf("alu%0d.in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk_outs($sformatf("alu%0d", i), 1'b1, vecs[i].exp_res,
               vecs[i].exp_z, vecs[i].exp_n, vecs[i].rg,
               vecs[i].exp_byte);
      last_res = vecs[i].exp_res;
    end
    in_valid = 1'b0;
    step();
    chk("idle.out_valid", 32'(out_valid), 32'd0);

    run_win("win1", {8'd10, 8'd200, 8'd200, 8'd7, 8'd255}, 8'd255, 0);
    run_win("win2", {8'd9, 8'd9, 8'd3, 8'd1, 8'd0}, 8'd9, 0);
    run_win("winz", 40'h0, 8'd0, 0);
    run_win("wstall", {8'd1, 8'd50, 8'd3, 8'd4, 8'd5}, 8'd50, 2);

    // Flush one cycle after a window accept.
    in_valid = 1'b1; sel_res = 1'b1;
    window = {8'd1, 8'd2, 8'd3, 8'd4, 8'd99};
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    issue_add(32'd2, 32'd3, 4'd6);
    step();
    in_valid = 1'b0;
    chk_outs("flush_add", 1'b1, 32'd5, 1'b0, 1'b0, 4'd6, 8'h03);
    for (int k = 0; k < NPIX; k++) begin
      step();
      chk("flush.no_late_valid", 32'(out_valid), 32'd0);
    end

    // A same-cycle accept under flush is dropped.
    issue_add(32'd8, 32'd8, 4'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop.out_valid", 32'(out_valid), 32'd0);

    // Reset held for 2 cycles in the middle of a reduction.
    in_valid = 1'b1; sel_res = 1'b1;
    window = {8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    chk_outs("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 8'h0);
    rst = 1'b0;
    #1;
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < NPIX; k++) begin
      step();
      chk("rst_mid.no_valid", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
